// File: rtl/clk_en_pkg.sv
// Shared constants and divisor helper for the clock-enable generator.
// Build option: CLK_EN_SIM_FAST_EN shrinks effective divisors for simulation.
package clk_en_pkg;

    localparam int CW_DEF        = 32;
    localparam int SIM_SHIFT_DEF = 10;

    localparam logic [CW_DEF-1:0] HP_2HZ   = 32'd25000000;
    localparam logic [CW_DEF-1:0] HP_1HZ   = 32'd50000000;
    localparam logic [CW_DEF-1:0] HP_FAST  = 32'd50000;
    localparam logic [CW_DEF-1:0] HP_BLINK = 32'd12500000;

    // Zero (or a value shifted down to zero) behaves as one.
    function automatic logic [CW_DEF-1:0] eff_div(
        input logic [CW_DEF-1:0] act,
        input int unsigned       sh
    );
        logic [CW_DEF-1:0] d;
        d = act >> sh;
        return (d == '0) ? CW_DEF'(1) : d;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel: counter, active/shadow divisor, square wave and tick.
// Build option: CLK_EN_SIM_FAST_EN applies SIM_SHIFT to the divisor.
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int              CW        = CW_DEF,
    parameter int              SIM_SHIFT = SIM_SHIFT_DEF,
    parameter logic [CW-1:0]   DIV_INIT  = CW'(1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync_i,
    input  logic          ch_en,
    input  logic          wr,
    input  logic [CW-1:0] wdata,
    output logic          sq,
    output logic          tick,
    output logic          pend
);

`ifdef CLK_EN_SIM_FAST_EN
    localparam int unsigned SH = SIM_SHIFT;
`else
    localparam int unsigned SH = 0 * SIM_SHIFT;
`endif

    logic [CW-1:0] cnt;
    logic [CW-1:0] act;
    logic [CW-1:0] shd;
    logic [CW-1:0] eff;
    logic          park;
    logic          wrap;
    logic          apply;

    assign eff   = CW'(eff_div(CW_DEF'(act), SH));
    assign park  = en && !ch_en;
    assign wrap  = en && ch_en && (cnt == eff - 1'b1);
    assign apply = pend && (sync_i || park || wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            act  <= DIV_INIT;
            shd  <= DIV_INIT;
            pend <= 1'b0;
            sq   <= 1'b0;
            tick <= 1'b0;
        end else begin
            // A write never lands at the same edge it is captured.
            if (apply) act <= shd;
            if (wr) shd <= wdata;
            pend <= wr || (pend && !apply);

            if (sync_i || park) begin
                cnt  <= '0;
                sq   <= 1'b0;
                tick <= 1'b0;
            end else if (!en) begin
                tick <= 1'b0;
            end else if (wrap) begin
                cnt  <= '0;
                sq   <= ~sq;
                tick <= ~sq;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable / square-wave generator with shadowed divisors.
// Build option: CLK_EN_SIM_FAST_EN (fast-simulation divisor shift).
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                NCH       = 4,
    parameter int                CW        = CW_DEF,
    parameter logic [NCH*CW-1:0] DIV_INIT  = {HP_BLINK, HP_FAST, HP_1HZ, HP_2HZ},
    parameter int                SIM_SHIFT = SIM_SHIFT_DEF,
    localparam int               SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync_i,
    input  logic [NCH-1:0] ch_en,
    input  logic           div_wr,
    input  logic [SW-1:0]  div_sel,
    input  logic [CW-1:0]  div_data,
    output logic [NCH-1:0] sq_o,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] pend_o
);

    // Out-of-range selects match no channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr;
        assign wr = div_wr && (div_sel == SW'(i));

        clk_en_chan #(
            .CW        (CW),
            .SIM_SHIFT (SIM_SHIFT),
            .DIV_INIT  (DIV_INIT[i*CW +: CW])
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .sync_i (sync_i),
            .ch_en  (ch_en[i]),
            .wr     (wr),
            .wdata  (div_data),
            .sq     (sq_o[i]),
            .tick   (tick_o[i]),
            .pend   (pend_o[i])
        );
    end

endmodule
